approx_mult_controller: RTL and testbench

- Control FSM for the 16-bit approximate-multiplier datapath. Sits directly upstream of it and drives all of its strobes: load, normalise A, normalise B, capture product, denormalise.
- Consumes the datapath status flags DoneA, DoneB and downDone.
- Exposes a start/ready/done handshake to the host.
- Adds zero-operand and timeout guards, which the datapath cannot detect itself.

---
 rtl/mult_pkg.sv | 28 ++
 rtl/approx_mult_controller.sv | 149 ++++++++++++++
 tb/tb_approx_mult_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the approximate-multiplier control path: FSM state
// encoding, default datapath sizing and the guard-counter width helper.
package mult_pkg;

    localparam int WIDTH          = 16;
    localparam int MAX_OUT_SHIFTS = 31;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_NORM_A    = 3'd2,
        S_NORM_B    = 3'd3,
        S_MULT      = 3'd4,
        S_SHIFT_OUT = 3'd5,
        S_FIN       = 3'd6
    } state_e;

    // The guard counter serves both normalisation (limit WIDTH-1) and
    // denormalisation (limit MAX_OUT_SHIFTS), so it must hold the larger.
    function automatic int guard_width(input int width, input int max_out);
        int lim;
        lim = (width - 1 > max_out) ? width - 1 : max_out;
        return $clog2(lim + 1);
    endfunction

    localparam int GUARD_W = guard_width(WIDTH, MAX_OUT_SHIFTS);

endpackage

// File: rtl/approx_mult_controller.sv
// Sequencing FSM for the 16-bit approximate multiplier: drives every datapath
// strobe and adds zero-operand and denormalisation-timeout guards.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | ready for host start
// LOAD        | capture operands, clear datapath shift counter
// NORM_A      | shift A left until its MSB is set (or give up: zero)
// NORM_B      | shift B left until its MSB is set (or give up: zero)
// MULT        | capture the product
// SHIFT_OUT   | shift result right until downDone (or give up: timeout)
// FIN         | one-cycle done pulse
module approx_mult_controller #(
    parameter int WIDTH          = mult_pkg::WIDTH,
    parameter int MAX_OUT_SHIFTS = mult_pkg::MAX_OUT_SHIFTS
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic DoneA,
    input  logic DoneB,
    input  logic downDone,
    output logic loadA,
    output logic loadB,
    output logic shlA,
    output logic shlB,
    output logic rst5,
    output logic cntU,
    output logic cntD,
    output logic loadOut,
    output logic shrOut,
    output logic ready,
    output logic done,
    output logic zero,
    output logic timeout
);
    import mult_pkg::*;

    localparam int GW = guard_width(WIDTH, MAX_OUT_SHIFTS);
    localparam logic [GW-1:0] NORM_LIMIT = GW'(WIDTH - 1);
    localparam logic [GW-1:0] OUT_LIMIT  = GW'(MAX_OUT_SHIFTS);

    state_e        state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          zero_q, zero_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        zero_d    = zero_q;
        timeout_d = timeout_q;
        loadA     = 1'b0;
        loadB     = 1'b0;
        shlA      = 1'b0;
        shlB      = 1'b0;
        rst5      = 1'b0;
        cntU      = 1'b0;
        cntD      = 1'b0;
        loadOut   = 1'b0;
        shrOut    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                loadA     = 1'b1;
                loadB     = 1'b1;
                rst5      = 1'b1;
                guard_d   = '0;
                zero_d    = 1'b0;
                timeout_d = 1'b0;
                state_d   = S_NORM_A;
            end
            S_NORM_A: begin
                if (DoneA) begin
                    guard_d = '0;
                    state_d = S_NORM_B;
                end else if (guard_q == NORM_LIMIT) begin
                    zero_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    shlA    = 1'b1;
                    cntU    = 1'b1;
                    guard_d = guard_q + GW'(1);
                end
            end
            S_NORM_B: begin
                if (DoneB) begin
                    guard_d = '0;
                    state_d = S_MULT;
                end else if (guard_q == NORM_LIMIT) begin
                    zero_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    shlB    = 1'b1;
                    cntU    = 1'b1;
                    guard_d = guard_q + GW'(1);
                end
            end
            S_MULT: begin
                loadOut = 1'b1;
                guard_d = '0;
                state_d = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                // downDone wins over the guard: a result that lands exactly on
                // the last permitted shift is not a timeout.
                if (downDone) begin
                    state_d = S_FIN;
                end else if (guard_q == OUT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    shrOut  = 1'b1;
                    cntD    = 1'b1;
                    guard_d = guard_q + GW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            guard_q   <= '0;
            zero_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            zero_q    <= zero_d;
            timeout_q <= timeout_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_FIN);
    assign zero    = zero_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_approx_mult_controller.sv
// Randomised scoreboard bench for approx_mult_controller with a behavioural
// datapath model that raises the status flags after a chosen number of shifts.
module tb_approx_mult_controller;
    import mult_pkg::*;

    logic clk = 1'b0;
    logic rst, start;
    logic DoneA, DoneB, downDone;
    logic loadA, loadB, shlA, shlB, rst5, cntU, cntD, loadOut, shrOut;
    logic ready, done, zero, timeout;

    int tests = 0;
    int fails = 0;

    approx_mult_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .DoneA(DoneA), .DoneB(DoneB), .downDone(downDone),
        .loadA(loadA), .loadB(loadB), .shlA(shlA), .shlB(shlB),
        .rst5(rst5), .cntU(cntU), .cntD(cntD), .loadOut(loadOut),
        .shrOut(shrOut), .ready(ready), .done(done), .zero(zero),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: each flag rises once the requested number of shifts
    // has been applied since the matching load.
    int na = 0, nb = 0, no = 0;
    int cnta = 0, cntb = 0, cnto = 0;
    always @(posedge clk) begin
        if (loadA) cnta <= 0; else if (shlA) cnta <= cnta + 1;
        if (loadB) cntb <= 0; else if (shlB) cntb <= cntb + 1;
        if (loadOut) cnto <= 0; else if (shrOut) cnto <= cnto + 1;
    end
    assign DoneA    = (cnta >= na);
    assign DoneB    = (cntb >= nb);
    assign downDone = (cnto >= no);

    typedef struct {
        int n_shla;
        int n_shlb;
        int n_shr;
        int n_loadout;
        int lat;
        bit zero;
        bit timeout;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the operation phase by phase. Latency counts edges from
    // the one that samples start to the one that enters the done cycle.
    function automatic exp_t model(input int a, input int b, input int o);
        exp_t e;
        int lim;
        lim = WIDTH - 1;
        e = '{default: 0};
        e.n_shla = (a > lim) ? lim : a;
        e.lat    = 1 + e.n_shla + 1;
        if (a > lim) begin
            e.zero = 1'b1;
            return e;
        end
        e.n_shlb = (b > lim) ? lim : b;
        e.lat    = e.lat + e.n_shlb + 1;
        if (b > lim) begin
            e.zero = 1'b1;
            return e;
        end
        e.n_loadout = 1;
        e.n_shr     = (o > MAX_OUT_SHIFTS) ? MAX_OUT_SHIFTS : o;
        e.timeout   = (o > MAX_OUT_SHIFTS);
        e.lat       = e.lat + 1 + e.n_shr + 1;
        return e;
    endfunction

    // Monitor: tallies strobes per operation and checks at every done pulse.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int accept_edge;
        int c_shla, c_shlb, c_shr, c_lo, c_la, c_lb, c_r5, c_cu, c_cd;
        bit active;
        exp_t e;
        active = 0;
        accept_edge = 0;
        c_shla = 0; c_shlb = 0; c_shr = 0; c_lo = 0;
        c_la = 0; c_lb = 0; c_r5 = 0; c_cu = 0; c_cd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
            end else begin
                tests++;
                if ((int'(shlA) + int'(shlB) + int'(shrOut)) > 1 || (cntU && cntD)) begin
                    fails++;
                    $display("FAIL strobe_exclusive: shlA=%0b shlB=%0b shrOut=%0b cntU=%0b cntD=%0b required at most one shift, not both counts",
                             shlA, shlB, shrOut, cntU, cntD);
                end
                if (ready && start) begin
                    accept_edge = cyc + 1;
                    active = 1;
                    c_shla = 0; c_shlb = 0; c_shr = 0; c_lo = 0;
                    c_la = 0; c_lb = 0; c_r5 = 0; c_cu = 0; c_cd = 0;
                end else if (active) begin
                    c_shla += int'(shlA); c_shlb += int'(shlB); c_shr += int'(shrOut);
                    c_lo += int'(loadOut); c_la += int'(loadA); c_lb += int'(loadB);
                    c_r5 += int'(rst5); c_cu += int'(cntU); c_cd += int'(cntD);
                end
                if (done) begin
                    if (!active || sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("shlA_count", c_shla, e.n_shla);
                        chk("shlB_count", c_shlb, e.n_shlb);
                        chk("shrOut_count", c_shr, e.n_shr);
                        chk("loadOut_count", c_lo, e.n_loadout);
                        chk("loadA_count", c_la, 1);
                        chk("loadB_count", c_lb, 1);
                        chk("rst5_count", c_r5, 1);
                        chk("cntU_count", c_cu, e.n_shla + e.n_shlb);
                        chk("cntD_count", c_cd, e.n_shr);
                        chk("latency", cyc - accept_edge, e.lat);
                        chk("zero", int'(zero), int'(e.zero));
                        chk("timeout", int'(timeout), int'(e.timeout));
                    end
                    active = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and return during its done cycle. With hold, start
    // stays high so the next call begins back-to-back; with noise, start is
    // toggled while busy and must be ignored.
    task automatic run_op(input int a, input int b, input int o,
                          input bit hold, input bit noise, input bit b2b);
        exp_t e;
        int k;
        e = model(a, b, o);
        na = a; nb = b; no = o;
        sb.push_back(e);
        start = 1'b1;
        k = 0;
        while (!ready && k < 6) begin
            step();
            k++;
        end
        if (b2b) chk("b2b_idle_wait", k, 1);
        if (!ready) begin
            chk("ready_wait_expired", 0, 1);
            return;
        end
        step();
        chk("load_after_accept", int'(loadA), 1);
        if (!hold) start = 1'b0;
        if (noise && e.lat >= 7) begin
            step();
            step();
            start = 1'b1;
            repeat (e.lat - 5) step();
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 400) begin
            step();
            k++;
        end
        if (!done) chk("done_wait_expired", 0, 1);
    endtask

    initial begin
        int a, b, o;
        rst = 1'b1;
        start = 1'b0;
        #23;
        chk("reset_strobes", int'({loadA, loadB, shlA, shlB, rst5, cntU, cntD, loadOut, shrOut}), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_zero", int'(zero), 0);
        chk("reset_timeout", int'(timeout), 0);
        step();
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(ready), 1);
        step();

        run_op(0, 0, 0, 0, 0, 0);
        run_op(3, 5, 2, 0, 0, 0);
        run_op(100, 0, 0, 0, 0, 0);
        run_op(0, 100, 0, 0, 0, 0);
        run_op(0, 0, 100, 0, 0, 0);
        run_op(15, 15, 31, 0, 0, 0);
        run_op(0, 0, 10, 0, 1, 0);
        step();

        // asynchronous reset mid-NORM_B
        na = 0; nb = 10; no = 0;
        sb.push_back(model(0, 10, 0));
        start = 1'b1;
        while (!ready) step();
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("in_normb_shlB", int'(shlB), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_strobes", int'({loadA, loadB, shlA, shlB, rst5, cntU, cntD, loadOut, shrOut}), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_ready", int'(ready), 1);
        void'(sb.pop_back());
        step();
        rst = 1'b0;
        #1;
        chk("ready_after_midrst", int'(ready), 1);
        repeat (4) begin
            step();
            chk("no_done_after_rst", int'(done), 0);
        end
        run_op(2, 1, 4, 0, 0, 0);
        step();

        // start held across two operations
        run_op(1, 2, 3, 1, 0, 0);
        run_op(2, 1, 0, 0, 0, 1);
        step();

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(7) == 0) ? 50 : int'($urandom_range(15));
            b = ($urandom_range(7) == 0) ? 50 : int'($urandom_range(15));
            o = ($urandom_range(7) == 0) ? 60 : int'($urandom_range(31));
            run_op(a, b, o, 0, ($urandom_range(3) == 0), 0);
            if ($urandom_range(1) == 1) step();
        end
        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
